reg_file_wr_sink: RTL and testbench

//  - Register bank at the receiving end of the write-select path: 16 x DATA_W storage.
//  - Written via an active-low one-hot select bus (rseln[15:0]) plus a write strobe.
//  - Two registered read ports (A, B) are addressed by 4-bit binary fields from the op decoder.
//  - Sits between the write-select decoder and the ALU operand latches; flags malformed select buses.

---
 rtl/reg_pkg.sv | 9 +
 rtl/onehot_n_enc.sv | 24 ++
 rtl/reg_file_wr_sink.sv | 100 ++++++++++
 tb/tb_reg_file_wr_sink.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared register-bank types, used by the write-select decoder and the register sink.
package reg_pkg;
    localparam int REG_IDX_W  = 4;
    localparam int NREG       = 16;
    localparam int REG_DATA_W = 16;

    typedef logic [REG_IDX_W-1:0]  reg_idx_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/onehot_n_enc.sv
// Active-low one-hot to binary index encoder; valid only when exactly one bit is low.
module onehot_n_enc
    import reg_pkg::*;
(
    input  logic [NREG-1:0] sel_n,
    output reg_idx_t        idx,
    output logic            valid
);

    logic [NREG-1:0] sel;

    always_comb begin
        sel = ~sel_n;
        idx = '0;
        for (int i = 0; i < NREG; i++) begin
            if (sel[i]) begin
                idx = REG_IDX_W'(i);
            end
        end
        // Clearing the lowest set bit leaves zero only for a single-bit vector.
        valid = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    end

endmodule

// File: rtl/reg_file_wr_sink.sv
// 16-entry register bank written through an active-low one-hot select, with two
// registered read ports, write-through bypass and a saturating malformed-select counter.
module reg_file_wr_sink
    import reg_pkg::*;
#(
    parameter int DATA_W    = REG_DATA_W,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [NREG-1:0]      rseln,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 rd_en,
    input  reg_idx_t             rd_addr_a,
    input  reg_idx_t             rd_addr_b,
    output logic [DATA_W-1:0]    rd_data_a,
    output logic [DATA_W-1:0]    rd_data_b,
    output logic                 rd_valid,
    output logic                 sel_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    reg_idx_t          wr_idx;
    logic              wr_sel_ok;
    logic              wr_ok;
    logic              wr_bad;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
    logic              rd_valid_q, rd_valid_d;
    logic              sel_err_q, sel_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    onehot_n_enc u_enc (
        .sel_n (rseln),
        .idx   (wr_idx),
        .valid (wr_sel_ok)
    );

    // Stage 0: decode the select bus and form next-state for storage and read ports.
    always_comb begin
        wr_ok  = wr_en && wr_sel_ok;
        wr_bad = wr_en && !wr_sel_ok;

        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[wr_idx] = wr_data;
        end

        // Reading the post-write view gives the write-through bypass on both ports.
        rd_data_a_d = rd_data_a_q;
        rd_data_b_d = rd_data_b_q;
        if (rd_en) begin
            rd_data_a_d = regs_d[rd_addr_a];
            rd_data_b_d = regs_d[rd_addr_b];
        end
        rd_valid_d = rd_en;

        sel_err_d = wr_bad;
        err_cnt_d = err_cnt_q;
        if (wr_bad && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Stage 1: registered storage and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            rd_valid_q  <= 1'b0;
            sel_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            rd_valid_q  <= rd_valid_d;
            sel_err_q   <= sel_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign rd_valid  = rd_valid_q;
    assign sel_err   = sel_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_reg_file_wr_sink.sv
// Randomized bench for reg_file_wr_sink against an array-based model of the register bank.
module tb_reg_file_wr_sink;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] rseln = 16'hFFFF;
    logic [15:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr_a = '0;
    logic [3:0]  rd_addr_b = '0;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        rd_valid;
    logic        sel_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Model state and the outputs expected after the most recent edge.
    logic [15:0] mregs [16];
    int          m_cnt;
    logic [15:0] exp_a, exp_b, nxt_a, nxt_b;
    logic        exp_valid, exp_err, nxt_valid, nxt_err;
    logic [7:0]  exp_cnt, nxt_cnt;

    reg_file_wr_sink #(.DATA_W(16), .ERR_CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .rseln     (rseln),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_valid  (rd_valid),
        .sel_err   (sel_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rd_data_a", {16'h0, rd_data_a}, {16'h0, exp_a});
            check("rd_data_b", {16'h0, rd_data_b}, {16'h0, exp_b});
            check("rd_valid",  {31'h0, rd_valid},  {31'h0, exp_valid});
            check("sel_err",   {31'h0, sel_err},   {31'h0, exp_err});
            check("err_cnt",   {24'h0, err_cnt},   {24'h0, exp_cnt});
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        m_cnt = 0;
        exp_a = '0; exp_b = '0; exp_valid = 1'b0; exp_err = 1'b0; exp_cnt = '0;
    endtask

    // Exactly one low bit of rseln names the target register; anything else is an error.
    task automatic model_step();
        nxt_valid = rd_en;
        nxt_err   = 1'b0;
        nxt_a     = exp_a;
        nxt_b     = exp_b;
        if (wr_en) begin
            if ($countones(~rseln) == 1) begin
                for (int i = 0; i < 16; i++)
                    if (!rseln[i]) mregs[i] = wr_data;
            end else begin
                nxt_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        if (rd_en) begin
            nxt_a = mregs[rd_addr_a];
            nxt_b = mregs[rd_addr_b];
        end
        nxt_cnt = m_cnt[7:0];
    endtask

    // Apply one cycle of inputs; returns 2 time units after the edge.
    task automatic cyc(input logic we, input logic [15:0] rs, input logic [15:0] wd,
                       input logic re, input logic [3:0] aa, input logic [3:0] ab);
        wr_en = we; rseln = rs; wr_data = wd;
        rd_en = re; rd_addr_a = aa; rd_addr_b = ab;
        model_step();
        @(posedge clk);
        exp_a = nxt_a; exp_b = nxt_b; exp_valid = nxt_valid;
        exp_err = nxt_err; exp_cnt = nxt_cnt;
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        check("rst_rd_data_a", {16'h0, rd_data_a}, 32'h0);
        check("rst_rd_data_b", {16'h0, rd_data_b}, 32'h0);
        check("rst_rd_valid",  {31'h0, rd_valid},  32'h0);
        check("rst_sel_err",   {31'h0, sel_err},   32'h0);
        check("rst_err_cnt",   {24'h0, err_cnt},   32'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        wr_en = 1'b0; rd_en = 1'b0; rseln = 16'hFFFF;
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] bad_sel();
        logic [15:0] r;
        r = 16'($urandom);
        if ($countones(~r) == 1) r = 16'hFFFF;
        return r;
    endfunction

    logic [15:0] hold_a, hold_b;

    initial begin
        model_clear();
        @(posedge clk);
        #2;
        do_reset();
        chk_en = 1'b1;

        // Every register reads zero after reset.
        for (int i = 0; i < 16; i++) cyc(1'b0, 16'hFFFF, 16'h0, 1'b1, 4'(i), 4'(15 - i));

        // Write/read sweep.
        for (int i = 0; i < 16; i++) cyc(1'b1, ~(16'h1 << i), 16'hA500 + 16'(i), 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 16'hFFFF, 16'h0, 1'b1, 4'(i), 4'(i));
            check("sweep_lit_a", {16'h0, rd_data_a}, 32'hA500 + 32'(i));
            check("sweep_lit_valid", {31'h0, rd_valid}, 32'h1);
        end

        // Reset arriving while a write is being presented discards it.
        wr_en = 1'b1; rseln = 16'hFFFE; wr_data = 16'h1234;
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1'b0, 16'hFFFF, 16'h0, 1'b1, 4'(i), 4'(i));
        cyc(1'b0, 16'hFFFF, 16'h0, 1'b1, 4'h0, 4'h3);
        check("post_reset_lit_a", {16'h0, rd_data_a}, 32'h0);

        // Write-through bypass on both ports.
        cyc(1'b1, ~(16'h1 << 5), 16'hBEEF, 1'b1, 4'h5, 4'h5);
        check("bypass_lit_a", {16'h0, rd_data_a}, 32'hBEEF);
        check("bypass_lit_b", {16'h0, rd_data_b}, 32'hBEEF);

        // Malformed selects.
        cyc(1'b1, 16'hFFFF, 16'h1111, 1'b0, 4'h0, 4'h0);
        check("bad_ffff_lit_err", {31'h0, sel_err}, 32'h1);
        cyc(1'b1, 16'hFFFC, 16'h2222, 1'b1, 4'h0, 4'h1);
        check("bad_fffc_lit_cnt", {24'h0, err_cnt}, 32'h2);
        check("bad_no_write_lit", {16'h0, rd_data_a}, 32'h0);
        cyc(1'b0, 16'hFFFF, 16'h3333, 1'b0, 4'h0, 4'h0);
        check("idle_ffff_lit_err", {31'h0, sel_err}, 32'h0);
        cyc(1'b0, 16'hFFFC, 16'h4444, 1'b0, 4'h0, 4'h0);
        check("idle_fffc_lit_cnt", {24'h0, err_cnt}, 32'h2);

        // Saturation.
        for (int i = 0; i < 300; i++) cyc(1'b1, bad_sel(), 16'($urandom), 1'b0, 4'h0, 4'h0);
        check("sat_lit_cnt", {24'h0, err_cnt}, 32'hFF);
        check("sat_lit_err", {31'h0, sel_err}, 32'h1);

        // Hold: writes to the addressed registers do not disturb idle read ports.
        cyc(1'b0, 16'hFFFF, 16'h0, 1'b1, 4'h2, 4'h7);
        hold_a = 16'hA502; hold_b = 16'hBEEF;
        hold_a = (4'h2 == 4'h2) ? mregs[2] : hold_a;
        hold_b = mregs[7];
        cyc(1'b1, ~(16'h1 << 2), 16'h5A5A, 1'b0, 4'h2, 4'h7);
        cyc(1'b1, ~(16'h1 << 7), 16'hC3C3, 1'b0, 4'h2, 4'h7);
        check("hold_lit_a", {16'h0, rd_data_a}, {16'h0, hold_a});
        check("hold_lit_b", {16'h0, rd_data_b}, {16'h0, hold_b});
        check("hold_lit_valid", {31'h0, rd_valid}, 32'h0);
        cyc(1'b0, 16'hFFFF, 16'h0, 1'b1, 4'h2, 4'h7);
        check("after_hold_lit_a", {16'h0, rd_data_a}, 32'h5A5A);
        check("after_hold_lit_b", {16'h0, rd_data_b}, 32'hC3C3);

        // Fresh reset, then mixed random traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [15:0] rs;
            logic [3:0]  aa;
            aa = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: rs = bad_sel();
                1: rs = ~(16'h1 << aa);
                default: rs = ~(16'h1 << $urandom_range(0, 15));
            endcase
            cyc(1'($urandom_range(0, 3) != 0), rs, 16'($urandom), 1'($urandom),
                aa, 4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
